// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop line synchroniser, falling-edge start detection,
// mid-bit sampling, framing-error detection and break (held-low line) handling.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = 217
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_dv,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [8:0] BIT_LAST  = 9'(CLKS_PER_BIT - 1);
  localparam logic [8:0] HALF_LAST = 9'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t     r_state;
  logic       r_rx_meta;
  logic       r_rx_s;
  logic       r_rx_d;
  logic [8:0] r_cnt;
  logic [2:0] r_bit_idx;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_dv;
  logic       r_frame_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_d      <= 1'b1;
      r_cnt       <= 9'd0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= i_rx;
      r_rx_s      <= r_rx_meta;
      r_rx_d      <= r_rx_s;
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_cnt <= 9'd0;
          if (r_rx_d && !r_rx_s) r_state <= S_START;
        end

        S_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= 9'd0;
            r_bit_idx <= 3'd0;
            // A line that is high again at mid-start was only a glitch.
            r_state   <= r_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        S_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= 9'd0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
            else                   r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        S_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt <= 9'd0;
            if (r_rx_s) begin
              r_data  <= r_shift;
              r_dv    <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 9'd1;
          end
        end

        S_BREAK: begin
          // Hold off until the line goes idle so a break is reported only once.
          r_cnt <= 9'd0;
          if (r_rx_s) r_state <= S_IDLE;
        end

        default: begin
          r_cnt   <= 9'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_data      = r_data;
  assign o_dv        = r_dv;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: a serial driver feeds frames and a queue-based
// reference model predicts every o_dv / o_frame_err pulse and its payload.
module tb_uart_rx;

  localparam int CPB    = 434;
  localparam int HALF   = 217;
  // Fall of i_rx -> pulse visible: 2 sync flops + edge detect, then start
  // sample at START cycle HALF-1, stop sample 9 bit periods later, pulse next cycle.
  localparam int DV_LAT = 3 + (HALF - 1) + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       dv;
  logic       ferr;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HALF)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .o_data      (data),
    .o_dv        (dv),
    .o_frame_err (ferr),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    int         lat_from;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;
  int         n_checks  = 0;
  int         n_pass    = 0;
  logic       prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: a good stop bit yields the byte, a low stop bit yields a
  // framing error that leaves the last good byte on o_data.
  task automatic model_frame(input logic [7:0] b, input logic stop, input int lat_from);
    exp_t e;
    e.is_ferr  = !stop;
    e.lat_from = lat_from;
    if (stop) begin
      e.data    = b;
      last_good = b;
    end else begin
      e.data = last_good;
    end
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge ending the stop bit.
  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop);
    rx = 1'b0;
    repeat (cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (cpb) @(negedge clk);
    end
    rx = stop;
    repeat (cpb) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (dv || ferr) begin
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      check("dv_ferr_excl", {31'd0, dv & ferr}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_ferr", {31'd0, ferr}, {31'd0, mon_e.is_ferr});
        check("o_data", {24'd0, data}, {24'd0, mon_e.data});
        if (mon_e.lat_from >= 0)
          check("dv_latency", cyc - mon_e.lat_from, DV_LAT);
        $display("rx %s data=%02h at cycle %0d", ferr ? "frame_err" : "byte", data, cyc);
      end
    end
    prev_pulse <= dv | ferr;
  end

  logic [7:0] rb;
  int         rcpb;
  int         t0;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_dv", {31'd0, dv}, 32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single nominal frame with exact latency and busy checks.
    model_frame(8'h41, 1'b1, cyc);
    fork
      send_frame(8'h41, CPB, 1'b1);
      begin
        repeat (2000) @(negedge clk);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
      end
    join
    repeat (5) @(negedge clk);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
    check("data_41_held", {24'd0, data}, 32'h41);

    // Back-to-back, no idle gap between stop and next start.
    model_frame(8'h55, 1'b1, -1); send_frame(8'h55, CPB, 1'b1);
    model_frame(8'hAA, 1'b1, -1); send_frame(8'hAA, CPB, 1'b1);
    model_frame(8'h00, 1'b1, -1); send_frame(8'h00, CPB, 1'b1);
    model_frame(8'hFF, 1'b1, -1); send_frame(8'hFF, CPB, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_all_seen", exp_q.size(), 32'd0);

    // Start-bit glitch: back in IDLE exactly at the mid-start sample.
    t0 = cyc;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (119) @(negedge clk);
    check("glitch_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("glitch_cycle", cyc - t0, 32'd220);
    check("glitch_busy_after", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    model_frame(8'h3C, 1'b1, -1); send_frame(8'h3C, CPB, 1'b1);
    repeat (20) @(negedge clk);

    // Framing error followed by a long break.
    model_frame(8'h81, 1'b0, -1); send_frame(8'h81, CPB, 1'b0);
    repeat (5000) @(negedge clk);
    check("break_busy", {31'd0, busy}, 32'd1);
    check("break_data_held", {24'd0, data}, {24'd0, last_good});
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("break_released", {31'd0, busy}, 32'd0);
    model_frame(8'h7E, 1'b1, -1); send_frame(8'h7E, CPB, 1'b1);
    repeat (20) @(negedge clk);

    // Baud tolerance, then random frames at random rates and gaps.
    model_frame(8'hC3, 1'b1, -1); send_frame(8'hC3, 425, 1'b1);
    repeat (20) @(negedge clk);
    model_frame(8'hC3, 1'b1, -1); send_frame(8'hC3, 443, 1'b1);
    repeat (20) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rb   = 8'($urandom);
      rcpb = int'($urandom_range(443, 425));
      model_frame(rb, 1'b1, -1);
      send_frame(rb, rcpb, 1'b1);
      repeat (int'($urandom_range(40, 1))) @(negedge clk);
    end

    // Reset during data bit 4: partial frame is dropped, o_data cleared.
    rb = 8'($urandom);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      repeat (CPB) @(negedge clk);
    end
    rx = rb[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_data", {24'd0, data}, 32'd0);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (10) @(negedge clk);
    check("postreset_data", {24'd0, data}, 32'd0);
    model_frame(8'h12, 1'b1, -1); send_frame(8'h12, CPB, 1'b1);

    for (int w = 0; w < 6000 && exp_q.size() != 0; w++) @(negedge clk);
    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_data", {24'd0, data}, 32'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
